io_port_ctrl: RTL and testbench

- Parametrised port-mapped I/O controller for board LEDs, switches, buttons and seven-segment display; attaches to the CPU port bus (port_read/port_write/port_addr).
- Generalises widths and digit count, relocates its register window via a base address, and adds per-button debounce plus sticky, read-to-clear press-event latching.
- Drives raw digit data to the existing seven-segment scanner through ssd_bits/ssd_char_mode.

---
 rtl/io_port_ctrl_pkg.sv | 27 ++
 rtl/io_debounce.sv | 52 +++++
 rtl/io_port_ctrl.sv | 143 ++++++++++++++
 tb/tb_io_port_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_ctrl_pkg.sv
// ============================================================================
// io_port_ctrl_pkg : register offsets and shared helpers for io_port_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package io_port_ctrl_pkg;

    localparam logic [2:0] IO_OFS_LED      = 3'd0;
    localparam logic [2:0] IO_OFS_HEX      = 3'd1;
    localparam logic [2:0] IO_OFS_CHAR     = 3'd2;
    localparam logic [2:0] IO_OFS_BITS     = 3'd3;
    localparam logic [2:0] IO_OFS_SWITCH   = 3'd4;
    localparam logic [2:0] IO_OFS_BUTTON   = 3'd5;
    localparam logic [2:0] IO_OFS_EVENTS   = 3'd6;
    localparam logic [2:0] IO_OFS_IRQ_MASK = 3'd7;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // Each hex nibble becomes its own character byte for the scanner.
    function automatic logic [31:0] hex_expand(input logic [15:0] d);
        return {4'h0, d[15:12], 4'h0, d[11:8], 4'h0, d[7:4], 4'h0, d[3:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ============================================================================
// io_debounce : two-flop synchroniser plus counter debounce for one input
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_debounce
    import io_port_ctrl_pkg::*;
#(
    parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             accept;

    assign mismatch = sync[1] ^ level;
    assign accept   = mismatch && (cnt == CNT_MAX);
    // Combinational so the rise lands on the same edge as the level change.
    assign rise     = accept && sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (!mismatch) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_port_ctrl.sv
// ============================================================================
// io_port_ctrl : port-mapped LED/switch/button/seven-segment controller
// Optional IRQ output and mask register enabled by macro IO_IRQ_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_port_ctrl
    import io_port_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR       = 16'h0010,
    parameter int          NUM_SW          = 8,
    parameter int          NUM_BTN         = 4,
    parameter int          NUM_LED         = 4,
    parameter int          NUM_DIGITS      = 4,
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SW-1:0]       sw,
    input  logic [NUM_BTN-1:0]      btn,
    output logic [NUM_LED-1:0]      led,
    output logic [8*NUM_DIGITS-1:0] ssd_bits,
    output logic                    ssd_char_mode,
    input  logic                    port_read,
    input  logic                    port_write,
    input  logic [15:0]             port_addr,
    input  logic [15:0]             port_write_data,
    output logic [15:0]             port_read_data
`ifdef IO_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int SSD_W = 8 * NUM_DIGITS;

    logic [NUM_SW-1:0]  sw_meta;
    logic [NUM_SW-1:0]  sw_sync;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] events;
    logic [15:0]        rel;
    logic [2:0]         ofs;
    logic               hit;
    logic               wr;
    logic               rd;
    logic [15:0]        rdata;
`ifdef IO_IRQ_EN
    logic [NUM_BTN-1:0] irq_mask;
`endif

    // Wrapping subtraction also rejects addresses below the base.
    assign rel = port_addr - BASE_ADDR;
    assign hit = (rel[15:3] == 13'd0);
    assign ofs = rel[2:0];
    assign wr  = port_write && hit;
    assign rd  = port_read && hit;

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            io_debounce #(
                .CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .raw   (btn[i]),
                .level (btn_level[i]),
                .rise  (btn_rise[i])
            );
        end
    endgenerate

    always_comb begin
        rdata = 16'h0000;
        case (ofs)
            IO_OFS_SWITCH:   rdata = 16'(sw_sync);
            IO_OFS_BUTTON:   rdata = 16'(btn_level);
            IO_OFS_EVENTS:   rdata = 16'(events);
`ifdef IO_IRQ_EN
            IO_OFS_IRQ_MASK: rdata = 16'(irq_mask);
`endif
            default:         rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta        <= '0;
            sw_sync        <= '0;
            led            <= '0;
            ssd_bits       <= '1;
            ssd_char_mode  <= 1'b0;
            port_read_data <= 16'h0000;
            events         <= '0;
        end else begin
            sw_meta        <= sw;
            sw_sync        <= sw_meta;
            port_read_data <= rd ? rdata : 16'h0000;
            // A rise arriving on the clearing edge survives the clear.
            if (rd && (ofs == IO_OFS_EVENTS)) begin
                events <= btn_rise;
            end else begin
                events <= events | btn_rise;
            end
            if (wr) begin
                case (ofs)
                    IO_OFS_LED: led <= port_write_data[NUM_LED-1:0];
                    IO_OFS_HEX: begin
                        ssd_bits      <= (ssd_bits << 32) | SSD_W'(hex_expand(port_write_data));
                        ssd_char_mode <= 1'b1;
                    end
                    IO_OFS_CHAR: begin
                        ssd_bits      <= (ssd_bits << 16) | SSD_W'(port_write_data);
                        ssd_char_mode <= 1'b1;
                    end
                    IO_OFS_BITS: begin
                        ssd_bits      <= (ssd_bits << 16) | SSD_W'(port_write_data);
                        ssd_char_mode <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && (ofs == IO_OFS_IRQ_MASK)) begin
                irq_mask <= port_write_data[NUM_BTN-1:0];
            end
            irq <= |(events & irq_mask);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
// ============================================================================
// tb_io_port_ctrl : directed self-checking bench for io_port_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_port_ctrl;

    localparam logic [15:0] BASE = 16'h0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sw = 8'h00;
    logic [3:0]  btn = 4'h0;
    logic [3:0]  led;
    logic [31:0] ssd_bits;
    logic        ssd_char_mode;
    logic        port_read = 1'b0;
    logic        port_write = 1'b0;
    logic [15:0] port_addr = 16'h0000;
    logic [15:0] port_write_data = 16'h0000;
    logic [15:0] port_read_data;
`ifdef IO_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    io_port_ctrl #(
        .BASE_ADDR       (BASE),
        .NUM_SW          (8),
        .NUM_BTN         (4),
        .NUM_LED         (4),
        .NUM_DIGITS      (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sw              (sw),
        .btn             (btn),
        .led             (led),
        .ssd_bits        (ssd_bits),
        .ssd_char_mode   (ssd_char_mode),
        .port_read       (port_read),
        .port_write      (port_write),
        .port_addr       (port_addr),
        .port_write_data (port_write_data),
        .port_read_data  (port_read_data)
`ifdef IO_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        port_addr       = addr;
        port_write_data = data;
        port_write      = 1'b1;
        @(negedge clk);
        port_write      = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        port_addr = addr;
        port_read = 1'b1;
        @(negedge clk);
        port_read = 1'b0;
        data      = port_read_data;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        sw = 8'hA5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL reset_led got %h want 0", led); end
        checks++; if (ssd_bits !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_ssd got %h want ffffffff", ssd_bits); end
        checks++; if (ssd_char_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", ssd_char_mode); end
        checks++; if (port_read_data !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", port_read_data); end
        repeat (3) @(negedge clk);
        do_read(BASE + 16'd4, d);
        checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL switch_read got %h want 00a5", d); end
        @(negedge clk);
        checks++; if (port_read_data !== 16'h0) begin errors++; $display("FAIL rdata_idle got %h want 0", port_read_data); end
    endtask

    task automatic test_led();
        logic [15:0] d;
        do_write(BASE, 16'hFFF9);
        checks++; if (led !== 4'h9) begin errors++; $display("FAIL led_write got %h want 9", led); end
        do_write(BASE + 16'd9, 16'h0000);
        checks++; if (led !== 4'h9) begin errors++; $display("FAIL out_of_window_led got %h want 9", led); end
        checks++; if (ssd_bits !== 32'hFFFFFFFF) begin errors++; $display("FAIL out_of_window_ssd got %h want ffffffff", ssd_bits); end
        do_read(BASE + 16'd1, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL writeonly_read got %h want 0", d); end
        do_read(BASE - 16'd1, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL below_window_read got %h want 0", d); end
    endtask

    task automatic test_display();
        do_write(BASE + 16'd1, 16'h1234);
        checks++; if (ssd_bits !== 32'h01020304) begin errors++; $display("FAIL hex_ssd got %h want 01020304", ssd_bits); end
        checks++; if (ssd_char_mode !== 1'b1) begin errors++; $display("FAIL hex_mode got %b want 1", ssd_char_mode); end
        do_write(BASE + 16'd3, 16'h7F06);
        checks++; if (ssd_bits !== 32'h03047F06) begin errors++; $display("FAIL bits_ssd got %h want 03047f06", ssd_bits); end
        checks++; if (ssd_char_mode !== 1'b0) begin errors++; $display("FAIL bits_mode got %b want 0", ssd_char_mode); end
        do_write(BASE + 16'd2, 16'h4142);
        checks++; if (ssd_bits !== 32'h7F064142) begin errors++; $display("FAIL char_ssd got %h want 7f064142", ssd_bits); end
        checks++; if (ssd_char_mode !== 1'b1) begin errors++; $display("FAIL char_mode got %b want 1", ssd_char_mode); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        port_addr       = BASE + 16'd4;
        port_write_data = 16'h0003;
        port_write      = 1'b1;
        port_read       = 1'b1;
        @(negedge clk);
        port_write = 1'b0;
        port_read  = 1'b0;
        checks++; if (port_read_data !== 16'h00A5) begin errors++; $display("FAIL rw_read got %h want 00a5", port_read_data); end
        checks++; if (led !== 4'h9) begin errors++; $display("FAIL rw_led got %h want 9", led); end
        @(negedge clk);
        port_addr       = BASE;
        port_write_data = 16'h0006;
        port_write      = 1'b1;
        port_read       = 1'b1;
        @(negedge clk);
        port_write = 1'b0;
        port_read  = 1'b0;
        checks++; if (led !== 4'h6) begin errors++; $display("FAIL rw_led_write got %h want 6", led); end
        checks++; if (port_read_data !== 16'h0) begin errors++; $display("FAIL rw_led_read got %h want 0", port_read_data); end
    endtask

    task automatic test_debounce();
        logic [15:0] d;
        // 3-cycle glitch on btn[2] must be rejected
        @(negedge clk); btn[2] = 1'b1;
        repeat (3) @(negedge clk);
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        do_read(BASE + 16'd5, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL glitch_button got %h want 0", d); end
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL glitch_events got %h want 0", d); end
        // held press
        @(negedge clk); btn[2] = 1'b1;
        repeat (10) @(negedge clk);
        do_read(BASE + 16'd5, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL press_button got %h want 0004", d); end
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL press_events got %h want 0004", d); end
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL events_cleared got %h want 0", d); end
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL release_no_event got %h want 0", d); end
    endtask

    task automatic test_event_coincident();
        logic [15:0] d;
        @(negedge clk); btn[3] = 1'b1;
        repeat (10) @(negedge clk);
        // btn[2] level accepted on the 6th rising edge after this negedge
        btn[2] = 1'b1;
        repeat (5) @(negedge clk);
        port_addr = BASE + 16'd6;
        port_read = 1'b1;
        @(negedge clk);
        port_read = 1'b0;
        d = port_read_data;
        checks++; if (d !== 16'h0008) begin errors++; $display("FAIL coincident_first got %h want 0008", d); end
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL coincident_kept got %h want 0004", d); end
        do_read(BASE + 16'd5, d);
        checks++; if (d !== 16'h000C) begin errors++; $display("FAIL level_both got %h want 000c", d); end
    endtask

`ifdef IO_IRQ_EN
    task automatic test_irq();
        logic [15:0] d;
        do_write(BASE + 16'd7, 16'h0001);
        do_read(BASE + 16'd7, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL mask_read got %h want 0001", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        @(negedge clk); btn[0] = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL irq_events got %h want 0001", d); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
        btn[1] = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq); end
    endtask
`endif

    task automatic test_async_reset();
        logic [15:0] d;
        do_write(BASE, 16'h000A);
        btn = 4'h0;
        @(negedge clk); btn[1] = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL async_led got %h want 0", led); end
        checks++; if (ssd_bits !== 32'hFFFFFFFF) begin errors++; $display("FAIL async_ssd got %h want ffffffff", ssd_bits); end
        btn = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        do_read(BASE + 16'd5, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL async_button got %h want 0", d); end
        do_read(BASE + 16'd6, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL async_events got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_display();
        test_simultaneous();
        test_debounce();
        test_event_coincident();
`ifdef IO_IRQ_EN
        btn = 4'h0;
        repeat (10) @(negedge clk);
        begin
            logic [15:0] d;
            do_read(BASE + 16'd6, d);
        end
        test_irq();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
